// File: rtl/multi_sevenseg.sv
// rtl/multi_sevenseg.sv - sequential double-dabble binary to multi-digit seven-segment driver
// Optional leading-zero blanking via `define LZ_BLANK_EN.
module multi_sevenseg #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    // Decimal digits needed to hold 2^w-1; sizes the BCD accumulator.
    function automatic int bcd_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 0) begin
            n = n + 1;
            v = v / 10;
        end
        return n;
    endfunction

    localparam int NB = bcd_digits(BIN_W);
    localparam int NX = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0011000;
            default: pattern = DASH;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_seg();
        logic [7*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
`ifdef LZ_BLANK_EN
            r[7*k +: 7] = (k == 0) ? pattern(4'd0) : BLANK;
`else
            r[7*k +: 7] = pattern(4'd0);
`endif
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RST = reset_seg();

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                state, state_nx;
    logic [BIN_W-1:0]      shreg;
    logic [4*NB-1:0]       bcd, bcd_adj;
    logic [4*NX-1:0]       bcd_ext;
    logic [CW-1:0]         cnt;
    logic [7*DIGITS-1:0]   seg_nx;
    logic                  ovf_nx;
    logic [3:0]            nib;
`ifdef LZ_BLANK_EN
    logic                  lead;
`endif

    assign busy    = (state != IDLE);
    assign bcd_ext = (4*NX)'(bcd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(BIN_W - 1)) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Display image from the finished accumulator, scanned from the top digit down.
    always_comb begin
        ovf_nx = 1'b0;
        seg_nx = '0;
        nib    = '0;
`ifdef LZ_BLANK_EN
        lead   = 1'b1;
`endif
        for (int i = DIGITS; i < NX; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) ovf_nx = 1'b1;
        end
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = bcd_ext[4*k +: 4];
`ifdef LZ_BLANK_EN
            if (nib != 4'd0) lead = 1'b0;
            seg_nx[7*k +: 7] = ovf_nx ? DASH : ((lead && k != 0) ? BLANK : pattern(nib));
`else
            seg_nx[7*k +: 7] = ovf_nx ? DASH : pattern(nib);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            seg      <= SEG_RST;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    shreg <= value;
                    bcd   <= '0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[4*NB-2:0], shreg[BIN_W-1]};
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                end
                UPDATE: begin
                    seg      <= seg_nx;
                    overflow <= ovf_nx;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_sevenseg.sv
// tb/tb_multi_sevenseg.sv - randomized self-checking bench for multi_sevenseg (5- and 4-digit instances)
module tb_multi_sevenseg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        busy5, done5, ovf5;
    logic        busy4, done4, ovf4;
    logic [34:0] seg5;
    logic [27:0] seg4;

    int vectors = 0;
    int errors  = 0;
    logic [69:0] cur5, cur4;

    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0011000};

    multi_sevenseg #(.BIN_W(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy5), .done(done5), .overflow(ovf5), .seg(seg5));

    multi_sevenseg #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy4), .done(done4), .overflow(ovf4), .seg(seg4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ovf(input int unsigned v, input int nd);
        longint unsigned lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (longint'(v) >= lim);
    endfunction

    function automatic logic [69:0] exp_seg(input int unsigned v, input int nd);
        logic [69:0] r = '0;
        int unsigned p = 1;
        logic blank;
        for (int k = 0; k < nd; k++) begin
`ifdef LZ_BLANK_EN
            blank = (k > 0) && (v < p);
`else
            blank = 1'b0;
`endif
            if (exp_ovf(v, nd)) r[7*k +: 7] = 7'b0111111;
            else if (blank)     r[7*k +: 7] = 7'b1111111;
            else                r[7*k +: 7] = PAT[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic do_conv(input logic [15:0] v, input bit noise);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(posedge clk); #1;
        check("busy_after_e0", busy5, 1'b1);
        check("done_after_e0", done5, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            load  = noise && (i == 5 || i == 17);
            value = 16'($urandom);
            @(posedge clk); #1;
            if (i < 17) begin
                check("busy_shift", busy5, 1'b1);
                check("done_early", done5, 1'b0);
                check("seg_hold", seg5, cur5);
            end
        end
        load = 1'b0;
        cur5 = exp_seg(v, 5);
        cur4 = exp_seg(v, 4);
        check("done_pulse", done5, 1'b1);
        check("busy_clear", busy5, 1'b0);
        check("seg5", seg5, cur5);
        check("ovf5", ovf5, exp_ovf(v, 5));
        check("done4", done4, 1'b1);
        check("busy4", busy4, 1'b0);
        check("seg4", seg4, cur4);
        check("ovf4", ovf4, exp_ovf(v, 4));
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load  = 1'b0;
            value = 16'($urandom);
            @(posedge clk); #1;
            check("idle_done", done5, 1'b0);
            check("idle_seg", seg5, cur5);
            check("idle_seg4", seg4, cur4);
        end
    endtask

    task automatic do_abort(input logic [15:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        cur5 = exp_seg(0, 5);
        cur4 = exp_seg(0, 4);
        check("abort_busy", busy5, 1'b0);
        check("abort_done", done5, 1'b0);
        check("abort_seg", seg5, cur5);
        check("abort_ovf", ovf5, 1'b0);
        check("abort_seg4", seg4, cur4);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done5, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        cur5 = exp_seg(0, 5);
        cur4 = exp_seg(0, 4);
        check("rst_busy", busy5, 1'b0);
        check("rst_done", done5, 1'b0);
        check("rst_ovf", ovf5, 1'b0);
        check("rst_seg", seg5, cur5);
        check("rst_seg4", seg4, cur4);
        rst_n = 1'b1;
        idle_gap(2);

        do_conv(16'd12345, 1'b0);
        do_conv(16'd65535, 1'b0);
        do_conv(16'd0,     1'b0);
        do_conv(16'd10000, 1'b0);
        do_conv(16'd9999,  1'b0);
        do_conv(16'd42,    1'b1);
        do_conv(16'd777,   1'b0);
        idle_gap(3);
        do_abort(16'd300);
        do_conv(16'd300,   1'b0);

        for (int n = 0; n < 40; n++) begin
            do_conv(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            idle_gap($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
